hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the core's fixed two-port forwarding/load-stall pair.
- Sits beside ID and tracks in-flight register writes across NUM_STAGES post-ID stages (default EX, MEM, WB) in an internal shift pipeline.
- Resolves NUM_SRC operands per cycle by youngest-match bypass and raises a load-use stall request when the youngest producer's result is not yet available.
- Per-instruction result latency replaces the hard-wired "load = stall one cycle" rule.

Parameters:
NUM_STAGES, 3, tracked stages after ID; index 0 = EX, NUM_STAGES-1 = WB.
NUM_SRC, 2, operand read ports.
REG_AW, 5, register address width.
DATA_W, 32, data width.
LAT_W, 2, width of the issue latency field.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
ext_stall  in  1  downstream freeze; all entries hold
flush  in  1  kill the instruction issuing from ID this cycle
issue_valid  in  1  ID holds a valid instruction
issue_wen  in  1  instruction writes a register
issue_waddr  in  REG_AW  destination register
issue_lat  in  LAT_W  stages after EX entry until result valid (ALU 0, load 1)
src_addr  in  NUM_SRC*REG_AW  operand register addresses, port i at [i*REG_AW +: REG_AW]
rf_rdata  in  NUM_SRC*DATA_W  register file read data
stage_wdata  in  NUM_STAGES*DATA_W  result currently held in stage k
src_data  out  NUM_SRC*DATA_W  resolved operands
src_fwd  out  NUM_SRC  port i was bypassed
stallreq  out  1  load-use hazard; ID/IF must hold
issue_fire  out  1  issue_valid & ~stallreq & ~ext_stall & ~flush

Behaviour:
- Entry k holds valid, waddr and rem. rem = remaining advances before stage_wdata[k] is valid for that entry.
- Reset (async): all valid=0 and rem=0.
  - Outputs after reset: stallreq=0, src_fwd=0, src_data=rf_rdata, issue_fire=issue_valid.
- Advance when ext_stall=0:
  - entry k+1 <= entry k, with rem decremented and saturating at 0.
  - entry NUM_STAGES-1 retires.
  - entry 0 <= {issue_wen, issue_waddr, min(issue_lat, NUM_STAGES-1)} if issue_fire, else a bubble (valid=0).
- Hold when ext_stall=1:
  - all entries hold.
  - if flush=1 in the same cycle, entry 0 valid is cleared in place.
- Lookup (combinational, per port i):
  - Candidates are valid entries with waddr==src_addr[i] and src_addr[i]!=0.
  - The lowest k (youngest) candidate wins.
  - Winner rem==0: src_data[i]=stage_wdata[k], src_fwd[i]=1.
  - Winner rem!=0: hazard; src_data[i]=rf_rdata[i], src_fwd[i]=0.
  - No candidate: src_data[i]=rf_rdata[i], src_fwd[i]=0.
- stallreq = issue_valid & OR of the per-port hazards.
  - Stalling inserts a bubble at entry 0 while older entries advance. A 1-latency load therefore resolves after exactly one stall cycle.
- The WB entry is a forwarding source because the register file has no write-through.
- Register 0 never matches.
- issue_wen=0 produces valid=0, which is treated as a bubble.
- Several ports matching the same entry are resolved independently and identically.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_fwd_cnt[31:0].
  - perf_stall_cnt increments on cycles with stallreq & ~ext_stall.
  - perf_fwd_cnt increments on issue_fire cycles with any src_fwd bit set.
  - Both wrap at 2^32 and are cleared by rst.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
1. Defaults (NUM_STAGES=3, NUM_SRC=2). rst pulsed; src_addr0=5, rf_rdata0=0x11 -> src_data0=0x11, src_fwd=0, stallreq=0.
2. Issue wen=1, waddr=3, lat=0. Next cycle src_addr0=3, stage_wdata[0]=0xAA -> src_data0=0xAA, src_fwd0=1, stallreq=0.
3. Issue waddr=4, lat=1 (load). Next cycle src_addr1=4 -> stallreq=1, issue_fire=0. Following cycle stage_wdata[1]=0x1234 -> src_data1=0x1234, stallreq=0, issue_fire=1.
4. Register 7 in stage 2 (data 0x1) and stage 0 (data 0x2), both rem=0; src_addr0=7 -> src_data0=0x2 (youngest wins).
5. Entry with waddr=0 in stage 0; src_addr0=0, rf_rdata0=0 -> src_fwd0=0, src_data0=0.
6. Load in stage 0 with consumer in ID; ext_stall=1 for 3 cycles -> stallreq stays 1 and entries unchanged. Assert rst mid-freeze -> stallreq drops to 0 immediately and all entries are invalid.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard beside ID: youngest-match operand bypass and load-use stall request.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard #(
    parameter int NUM_STAGES = 3,
    parameter int NUM_SRC    = 2,
    parameter int REG_AW     = 5,
    parameter int DATA_W     = 32,
    parameter int LAT_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ext_stall,
    input  logic                         flush,
    input  logic                         issue_valid,
    input  logic                         issue_wen,
    input  logic [REG_AW-1:0]            issue_waddr,
    input  logic [LAT_W-1:0]             issue_lat,
    input  logic [NUM_SRC*REG_AW-1:0]    src_addr,
    input  logic [NUM_SRC*DATA_W-1:0]    rf_rdata,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_wdata,
    output logic [NUM_SRC*DATA_W-1:0]    src_data,
    output logic [NUM_SRC-1:0]           src_fwd,
    output logic                         stallreq,
    output logic                         issue_fire
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_stall_cnt,
    output logic [31:0]                  perf_fwd_cnt
`endif
);

    localparam int MAX_REM = NUM_STAGES - 1;

    logic              ent_valid [NUM_STAGES];
    logic [REG_AW-1:0] ent_waddr [NUM_STAGES];
    logic [LAT_W-1:0]  ent_rem   [NUM_STAGES];

    logic [NUM_SRC-1:0] hazard;
    logic [LAT_W-1:0]   issue_rem;

    // Handshake: issue_valid offers an instruction from ID; issue_fire is the accept strobe
    // (valid & ~stallreq & ~ext_stall & ~flush) and only a fired instruction enters EX.
    assign stallreq   = issue_valid & (|hazard);
    assign issue_fire = issue_valid & ~stallreq & ~ext_stall & ~flush;

    // A result can never be later than WB, so the latency is clamped to the pipeline depth.
    always_comb begin
        issue_rem = issue_lat;
        if (int'(issue_lat) > MAX_REM) begin
            issue_rem = LAT_W'(MAX_REM);
        end
    end

    // Scan oldest to youngest so the youngest matching entry overrides older ones.
    always_comb begin
        src_data = '0;
        src_fwd  = '0;
        hazard   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_data[i*DATA_W +: DATA_W] = rf_rdata[i*DATA_W +: DATA_W];
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (ent_valid[k] && (src_addr[i*REG_AW +: REG_AW] != '0) &&
                    (ent_waddr[k] == src_addr[i*REG_AW +: REG_AW])) begin
                    if (ent_rem[k] == '0) begin
                        src_data[i*DATA_W +: DATA_W] = stage_wdata[k*DATA_W +: DATA_W];
                        src_fwd[i] = 1'b1;
                        hazard[i]  = 1'b0;
                    end else begin
                        src_data[i*DATA_W +: DATA_W] = rf_rdata[i*DATA_W +: DATA_W];
                        src_fwd[i] = 1'b0;
                        hazard[i]  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                ent_valid[k] <= 1'b0;
                ent_waddr[k] <= '0;
                ent_rem[k]   <= '0;
            end
        end else if (!ext_stall) begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_waddr[k] <= ent_waddr[k-1];
                ent_rem[k]   <= (ent_rem[k-1] == '0) ? '0 : ent_rem[k-1] - 1'b1;
            end
            // A non-writing or non-fired instruction enters as a bubble.
            ent_valid[0] <= issue_fire & issue_wen;
            ent_waddr[0] <= issue_waddr;
            ent_rem[0]   <= issue_rem;
        end else if (flush) begin
            ent_valid[0] <= 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else begin
            if (stallreq && !ext_stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (issue_fire && (|src_fwd)) begin
                perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard at default parameters (3 stages, 2 ports).
// Perf outputs are connected only when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        ext_stall;
    logic        flush;
    logic        issue_valid;
    logic        issue_wen;
    logic [4:0]  issue_waddr;
    logic [1:0]  issue_lat;
    logic [9:0]  src_addr;
    logic [63:0] rf_rdata;
    logic [95:0] stage_wdata;
    logic [63:0] src_data;
    logic [1:0]  src_fwd;
    logic        stallreq;
    logic        issue_fire;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_fwd_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .ext_stall   (ext_stall),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_wen   (issue_wen),
        .issue_waddr (issue_waddr),
        .issue_lat   (issue_lat),
        .src_addr    (src_addr),
        .rf_rdata    (rf_rdata),
        .stage_wdata (stage_wdata),
        .src_data    (src_data),
        .src_fwd     (src_fwd),
        .stallreq    (stallreq),
        .issue_fire  (issue_fire)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        ext_stall   = 1'b0;
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_wen   = 1'b0;
        issue_waddr = 5'd0;
        issue_lat   = 2'd0;
        src_addr    = 10'd0;
        rf_rdata    = {32'h0000_0055, 32'h0000_0044};
        stage_wdata = 96'd0;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (3) step();
    endtask

    task automatic issue(input logic [4:0] waddr, input logic [1:0] lat);
        issue_valid = 1'b1;
        issue_wen   = 1'b1;
        issue_waddr = waddr;
        issue_lat   = lat;
        src_addr    = 10'd0;
        #1;
        checks++; if (issue_fire !== 1'b1) begin failures++; $display("FAIL issue_fire_r%0d got=%b exp=1", waddr, issue_fire); end
        step();
        issue_valid = 1'b0;
        issue_wen   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) step();
        src_addr[4:0]  = 5'd5;
        rf_rdata[31:0] = 32'h11;
        issue_valid    = 1'b1;
        #1;
        checks++; if (src_data[31:0] !== 32'h11) begin failures++; $display("FAIL reset_data0 got=%h exp=%h", src_data[31:0], 32'h11); end
        checks++; if (src_fwd !== 2'b00) begin failures++; $display("FAIL reset_fwd got=%b exp=00", src_fwd); end
        checks++; if (stallreq !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stallreq); end
        checks++; if (issue_fire !== 1'b1) begin failures++; $display("FAIL reset_fire got=%b exp=1", issue_fire); end
        rst = 1'b0;
        idle_inputs();
        step();
    endtask

    task automatic test_alu_forward();
        issue(5'd3, 2'd0);
        issue_valid = 1'b1;
        src_addr    = {5'd3, 5'd3};
        stage_wdata[31:0] = 32'hAA;
        #1;
        checks++; if (src_data !== {32'hAA, 32'hAA}) begin failures++; $display("FAIL alu_fwd_data got=%h exp=%h", src_data, {32'hAA, 32'hAA}); end
        checks++; if (src_fwd !== 2'b11) begin failures++; $display("FAIL alu_fwd_bits got=%b exp=11", src_fwd); end
        checks++; if (stallreq !== 1'b0) begin failures++; $display("FAIL alu_fwd_stall got=%b exp=0", stallreq); end
        step();
        issue_valid = 1'b0;
        step();
        src_addr = {5'd0, 5'd3};
        stage_wdata[95:64] = 32'hBEEF;
        #1;
        checks++; if (src_data[31:0] !== 32'hBEEF || src_fwd !== 2'b01) begin failures++; $display("FAIL wb_fwd got=%h/%b exp=%h/01", src_data[31:0], src_fwd, 32'hBEEF); end
        step();
        #1;
        checks++; if (src_data[31:0] !== 32'h44 || src_fwd !== 2'b00) begin failures++; $display("FAIL retired got=%h/%b exp=%h/00", src_data[31:0], src_fwd, 32'h44); end
        drain();
    endtask

    task automatic test_load_use();
        issue(5'd4, 2'd1);
        issue_valid = 1'b1;
        src_addr    = {5'd4, 5'd0};
        rf_rdata[63:32] = 32'h99;
        #1;
        checks++; if (stallreq !== 1'b1) begin failures++; $display("FAIL load_stall got=%b exp=1", stallreq); end
        checks++; if (issue_fire !== 1'b0) begin failures++; $display("FAIL load_fire_held got=%b exp=0", issue_fire); end
        checks++; if (src_data[63:32] !== 32'h99 || src_fwd !== 2'b00) begin failures++; $display("FAIL load_hazard_data got=%h/%b exp=%h/00", src_data[63:32], src_fwd, 32'h99); end
        step();
        stage_wdata[63:32] = 32'h1234;
        #1;
        checks++; if (stallreq !== 1'b0) begin failures++; $display("FAIL load_resolved_stall got=%b exp=0", stallreq); end
        checks++; if (issue_fire !== 1'b1) begin failures++; $display("FAIL load_resolved_fire got=%b exp=1", issue_fire); end
        checks++; if (src_data[63:32] !== 32'h1234 || src_fwd !== 2'b10) begin failures++; $display("FAIL load_resolved_data got=%h/%b exp=%h/10", src_data[63:32], src_fwd, 32'h1234); end
        drain();
    endtask

    task automatic test_lat_saturate();
        issue(5'd12, 2'd3);
        issue_valid = 1'b1;
        src_addr    = {5'd0, 5'd12};
        stage_wdata[95:64] = 32'hC0DE;
        #1;
        checks++; if (stallreq !== 1'b1) begin failures++; $display("FAIL sat_stall_ex got=%b exp=1", stallreq); end
        step();
        #1;
        checks++; if (stallreq !== 1'b1) begin failures++; $display("FAIL sat_stall_mem got=%b exp=1", stallreq); end
        step();
        #1;
        checks++; if (stallreq !== 1'b0) begin failures++; $display("FAIL sat_stall_wb got=%b exp=0", stallreq); end
        checks++; if (src_data[31:0] !== 32'hC0DE || src_fwd !== 2'b01) begin failures++; $display("FAIL sat_wb_data got=%h/%b exp=%h/01", src_data[31:0], src_fwd, 32'hC0DE); end
        drain();
    endtask

    task automatic test_youngest();
        issue(5'd7, 2'd0);
        step();
        issue(5'd7, 2'd0);
        src_addr = {5'd0, 5'd7};
        stage_wdata = {32'h1, 32'h0, 32'h2};
        #1;
        checks++; if (src_data[31:0] !== 32'h2 || src_fwd !== 2'b01) begin failures++; $display("FAIL youngest got=%h/%b exp=%h/01", src_data[31:0], src_fwd, 32'h2); end
        drain();
    endtask

    task automatic test_reg_zero_and_nowrite();
        issue(5'd0, 2'd0);
        src_addr = 10'd0;
        rf_rdata[31:0] = 32'h0;
        stage_wdata[31:0] = 32'hFF;
        #1;
        checks++; if (src_data[31:0] !== 32'h0 || src_fwd !== 2'b00) begin failures++; $display("FAIL reg_zero got=%h/%b exp=0/00", src_data[31:0], src_fwd); end
        issue_valid = 1'b1;
        issue_wen   = 1'b0;
        issue_waddr = 5'd9;
        step();
        issue_valid = 1'b0;
        src_addr = {5'd0, 5'd9};
        rf_rdata[31:0] = 32'h77;
        #1;
        checks++; if (src_data[31:0] !== 32'h77 || src_fwd !== 2'b00) begin failures++; $display("FAIL no_write got=%h/%b exp=%h/00", src_data[31:0], src_fwd, 32'h77); end
        drain();
    endtask

    task automatic test_flush();
        issue_valid = 1'b1;
        issue_wen   = 1'b1;
        issue_waddr = 5'd6;
        flush       = 1'b1;
        #1;
        checks++; if (issue_fire !== 1'b0) begin failures++; $display("FAIL flush_fire got=%b exp=0", issue_fire); end
        step();
        idle_inputs();
        src_addr = {5'd0, 5'd6};
        stage_wdata[31:0] = 32'h66;
        #1;
        checks++; if (src_fwd !== 2'b00) begin failures++; $display("FAIL flush_killed got=%b exp=00", src_fwd); end
        drain();
        issue(5'd6, 2'd0);
        ext_stall = 1'b1;
        flush     = 1'b1;
        step();
        idle_inputs();
        src_addr = {5'd0, 5'd6};
        stage_wdata[31:0] = 32'h66;
        #1;
        checks++; if (src_fwd !== 2'b00) begin failures++; $display("FAIL flush_in_stall got=%b exp=00", src_fwd); end
        drain();
    endtask

    task automatic test_freeze_reset();
        issue(5'd8, 2'd1);
        issue_valid = 1'b1;
        src_addr    = {5'd0, 5'd8};
        ext_stall   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (stallreq !== 1'b1 || issue_fire !== 1'b0) begin failures++; $display("FAIL freeze_cycle%0d got=%b/%b exp=1/0", c, stallreq, issue_fire); end
            step();
        end
        #1;
        checks++; if (stallreq !== 1'b1) begin failures++; $display("FAIL freeze_held got=%b exp=1", stallreq); end
        rst = 1'b1;
        #1;
        checks++; if (stallreq !== 1'b0 || issue_fire !== 1'b0) begin failures++; $display("FAIL freeze_rst got=%b/%b exp=0/0", stallreq, issue_fire); end
        rst = 1'b0;
        ext_stall = 1'b0;
        #1;
        checks++; if (stallreq !== 1'b0 || issue_fire !== 1'b1 || src_fwd !== 2'b00) begin failures++; $display("FAIL post_rst got=%b/%b/%b exp=0/1/00", stallreq, issue_fire, src_fwd); end
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_load_use();
        test_lat_saturate();
        test_youngest();
        test_reg_zero_and_nowrite();
        test_flush();
        test_freeze_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
